// File: rtl/cnn_frame_feeder.sv
// Buffers one raster frame from the host, replays it gap-free to the CNN, then
// waits for a class decision (or a timeout) and hands the result back to the host.
module cnn_frame_feeder #(
  parameter int IMG_PIXELS = 784,
  parameter int PIX_BITS   = 8,
  parameter int ADDR_BITS  = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  input  logic [PIX_BITS-1:0] wr_data,
  output logic                wr_ready,
  output logic [PIX_BITS-1:0] pix_out,
  output logic                pix_valid,
  output logic                frame_start,
  input  logic                dec_valid,
  input  logic [3:0]          dec_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [3:0]          res_class,
  output logic                res_timeout,
  output logic                busy
);

  localparam int CNT_BITS = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(IMG_PIXELS - 1);
  localparam logic [CNT_BITS-1:0]  LAST_CNT  = CNT_BITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT, REPORT} state_t;

  state_t               state_reg;
  logic [ADDR_BITS-1:0] wr_addr_reg;
  logic [ADDR_BITS-1:0] rd_addr_reg;
  logic [CNT_BITS-1:0]  tmo_cnt_reg;
  logic [PIX_BITS-1:0]  frame_mem [IMG_PIXELS];
  logic                 wr_en;
  logic                 rd_en;

  // Note: rst_n is active-high despite its name.
  assign wr_ready = (state_reg == LOAD);
  assign busy     = (state_reg != LOAD);
  assign wr_en    = wr_valid && (state_reg == LOAD) && !rst_n;
  assign rd_en    = (state_reg == STREAM);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_mem[wr_addr_reg] <= wr_data;
    end
  end

  // Registered read port; it holds the last streamed pixel between frames.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pix_out <= '0;
    end else if (rd_en) begin
      pix_out <= frame_mem[rd_addr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= LOAD;
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
      tmo_cnt_reg <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      res_valid   <= 1'b0;
      res_class   <= 4'h0;
      res_timeout <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (wr_valid) begin
            if (wr_addr_reg == LAST_ADDR) begin
              wr_addr_reg <= '0;
              rd_addr_reg <= '0;
              state_reg   <= STREAM;
            end else begin
              wr_addr_reg <= wr_addr_reg + 1'b1;
            end
          end
        end
        STREAM: begin
          // Valid/start flags lag the address by one cycle to match the read latency.
          pix_valid   <= 1'b1;
          frame_start <= (rd_addr_reg == '0);
          if (rd_addr_reg == LAST_ADDR) begin
            rd_addr_reg <= '0;
            tmo_cnt_reg <= '0;
            state_reg   <= WAIT;
          end else begin
            rd_addr_reg <= rd_addr_reg + 1'b1;
          end
        end
        WAIT: begin
          if (dec_valid) begin
            res_class   <= dec_in;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state_reg   <= REPORT;
          end else if (tmo_cnt_reg == LAST_CNT) begin
            res_class   <= 4'hF;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state_reg   <= REPORT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed-sequence bench with random pixel data and random decision noise,
// checked against a frame array model and cycle counts derived from the feeder's rules.
module tb_cnn_frame_feeder;

  localparam int N   = 784;
  localparam int TMO = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic       frame_start;
  logic       dec_valid;
  logic [3:0] dec_in;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_class;
  logic       res_timeout;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  int         wait_edges;
  logic [7:0] frame [N];
  logic [3:0] cls;

  always #5 clk = ~clk;

  cnn_frame_feeder #(
    .IMG_PIXELS(N), .PIX_BITS(8), .ADDR_BITS(10), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .pix_out(pix_out), .pix_valid(pix_valid), .frame_start(frame_start),
    .dec_valid(dec_valid), .dec_in(dec_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_timeout(res_timeout), .busy(busy)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_frame(input bit ramp);
    for (int i = 0; i < N; i++) frame[i] = ramp ? 8'(i % 256) : 8'($urandom);
  endtask

  // mode 0: wr_valid held, 1: strict 1/0 toggle, 2: random gaps
  task automatic load_frame(input int mode, input int beats, input bit noise);
    int   i = 0;
    int   cyc = 0;
    logic v;
    logic rdy;
    while (i < beats && cyc < 8 * N) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      wr_valid  = v;
      wr_data   = v ? frame[i] : 8'($urandom);
      dec_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dec_in    = 4'($urandom);
      rdy = wr_ready;
      step();
      if (v && rdy) i++;
      cyc++;
    end
    wr_valid  = 1'b0;
    dec_valid = 1'b0;
    chk("load_beats", i, beats);
  endtask

  task automatic check_stream(input bit noise);
    chk("stream_entry_idle", pix_valid, 0);
    for (int c = 1; c <= N + 2; c++) begin
      dec_valid = (noise && c <= N) ? 1'($urandom_range(0, 1)) : 1'b0;
      dec_in    = 4'($urandom);
      step();
      if (c <= N) begin
        chk("pix_valid", pix_valid, 1);
        chk("pix_out", pix_out, frame[c-1]);
        chk("frame_start", frame_start, (c == 1));
        chk("res_valid_stream", res_valid, 0);
      end else begin
        chk("pix_valid_after", pix_valid, 0);
        chk("pix_out_hold", pix_out, frame[N-1]);
        chk("frame_start_after", frame_start, 0);
      end
    end
    dec_valid  = 1'b0;
    wait_edges = 2;
  endtask

  task automatic decide_at(input int target, input logic [3:0] c);
    while (wait_edges < target - 1) begin
      step();
      wait_edges++;
    end
    chk("wait_no_result", res_valid, 0);
    chk("wait_busy", busy, 1);
    dec_valid = 1'b1;
    dec_in    = c;
    step();
    wait_edges++;
    dec_valid = 1'b0;
    chk("dec_res_valid", res_valid, 1);
    chk("dec_res_class", res_class, c);
    chk("dec_res_timeout", res_timeout, 0);
  endtask

  task automatic ack(input logic [3:0] c, input logic tmo);
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dec_valid = 1'b1;
      dec_in    = ~c;
      step();
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_class", res_class, c);
      chk("hold_res_timeout", res_timeout, tmo);
      chk("hold_wr_ready", wr_ready, 0);
    end
    dec_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("ack_res_valid", res_valid, 0);
    chk("ack_wr_ready", wr_ready, 1);
    chk("ack_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b1; wr_valid = 1'b0; wr_data = 8'h0;
    dec_valid = 1'b0; dec_in = 4'h0; res_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_class", res_class, 0);
    chk("rst_res_timeout", res_timeout, 0);

    // Ramp frame, wr_valid held; decision 100 cycles into WAIT.
    fill_frame(1'b1);
    load_frame(0, N, 1'b0);
    chk("loaded_wr_ready", wr_ready, 0);
    chk("loaded_busy", busy, 1);
    check_stream(1'b0);
    decide_at(100, 4'd7);
    ack(4'd7, 1'b0);

    // Random frame, toggled beats, decision noise in LOAD/STREAM; then timeout.
    fill_frame(1'b0);
    load_frame(1, N, 1'b1);
    check_stream(1'b1);
    while (!res_valid && wait_edges < TMO + 50) begin
      step();
      wait_edges++;
    end
    chk("tmo_edges", wait_edges, TMO);
    chk("tmo_res_class", res_class, 4'hF);
    chk("tmo_res_timeout", res_timeout, 1);
    ack(4'hF, 1'b1);

    // Random gaps; decision lands on the final timeout cycle and must win.
    fill_frame(1'b0);
    load_frame(2, N, 1'b1);
    check_stream(1'b0);
    cls = 4'($urandom_range(0, 14));
    decide_at(TMO, cls);
    ack(cls, 1'b0);

    // Reset at pixel 400 of the stream.
    fill_frame(1'b0);
    load_frame(0, N, 1'b0);
    for (int c = 1; c <= 400; c++) begin
      step();
      chk("part_pix_out", pix_out, frame[c-1]);
    end
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_wr_ready", wr_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_pix_out", pix_out, 0);

    // Reset mid-load, then a fresh full frame must stream from address 0.
    fill_frame(1'b0);
    load_frame(0, 300, 1'b0);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("abort_load_wr_ready", wr_ready, 1);
    fill_frame(1'b0);
    load_frame(2, N, 1'b0);
    check_stream(1'b0);
    cls = 4'($urandom_range(0, 15));
    decide_at(50, cls);
    ack(cls, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
